// File: rtl/mod_reduction_scheduler.sv
// Round-robin scheduler sharing one modular-reduction unit among NUM_REQ requesters, one op in flight.
// Optional watchdog (macro MODRED_TIMEOUT_EN) aborts a reduction that never reports done.
module mod_reduction_scheduler_lane #(
  parameter int AW = 256
) (
  input  logic          gnt,
  input  logic [AW-1:0] a,
  output logic [AW-1:0] sel
);
  assign sel = gnt ? a : '0;
endmodule

module mod_reduction_scheduler #(
  parameter int P              = 37,
  parameter int WIDTH          = 128,
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*2*WIDTH-1:0] req_a,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [WIDTH-1:0]           rsp_r,
  output logic                       rsp_err,
  output logic                       red_reset,
  output logic                       red_enable,
  output logic [2*WIDTH-1:0]         red_a,
  input  logic                       red_done,
  input  logic [WIDTH-1:0]           red_r
);
  localparam int AW = 2*WIDTH;
  localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || ID_W != $clog2(NUM_REQ)) begin : g_cfg_err
    $error("mod_reduction_scheduler: bad NUM_REQ/ID_W");
  end
  if (P < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_err2
    $error("mod_reduction_scheduler: bad P/TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] r;
    logic             err;
  } rsp_t;

  state_t                     state, nstate;
  rsp_t                       rsp_q;
  logic [ID_W-1:0]            rr_ptr, tag, gnt_idx;
  logic [ID_W:0]              idx, nxt_ptr;
  logic [NUM_REQ-1:0]         grant;
  logic [NUM_REQ-1:0][AW-1:0] lane_a;
  logic [AW-1:0]              gnt_a;
  logic                       xfer, take, tmo;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    mod_reduction_scheduler_lane #(.AW(AW)) u_lane (
      .gnt (grant[i]),
      .a   (req_a[i*AW +: AW]),
      .sel (lane_a[i])
    );
  end

  // First valid requester at or after rr_ptr, searching with wrap.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + k[ID_W:0];
      if (idx >= NREQ) idx = idx - NREQ;
      if (grant == '0 && req_valid[idx[ID_W-1:0]]) begin
        grant[idx[ID_W-1:0]] = 1'b1;
        gnt_idx              = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_a = '0;
    for (int i = 0; i < NUM_REQ; i++) gnt_a |= lane_a[i];
  end

  always_comb begin
    nxt_ptr = {1'b0, gnt_idx} + (ID_W+1)'(1);
    if (nxt_ptr == NREQ) nxt_ptr = '0;
  end

  assign req_ready  = (state == IDLE && !reset) ? grant : '0;
  assign xfer       = |req_ready;
  assign take       = (state == WAIT) && red_done;
  assign red_enable = (state == ISSUE) && !reset;
  assign rsp_valid  = (state == RESP) && !reset;
  assign rsp_id     = rsp_q.id;
  assign rsp_r      = rsp_q.r;
  assign rsp_err    = rsp_q.err;

`ifdef MODRED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES-1);
  logic [CNT_W-1:0] wait_cnt;

  // A done arriving in the expiry cycle still completes normally.
  assign tmo       = (state == WAIT) && !red_done && (wait_cnt == TMO_LAST);
  assign red_reset = reset | tmo;

  always_ff @(posedge clk) begin
    if (reset || state == ISSUE) wait_cnt <= '0;
    else if (state == WAIT)      wait_cnt <= wait_cnt + CNT_W'(1);
  end
`else
  assign tmo       = 1'b0;
  assign red_reset = reset;
`endif

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (xfer) nstate = ISSUE;
      ISSUE:   nstate = WAIT;
      WAIT:    if (take || tmo) nstate = RESP;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      tag    <= '0;
      red_a  <= '0;
      rsp_q  <= '0;
    end else begin
      state <= nstate;
      if (xfer) begin
        red_a  <= gnt_a;
        tag    <= gnt_idx;
        rr_ptr <= nxt_ptr[ID_W-1:0];
      end
      if (take)     rsp_q <= {tag, red_r, 1'b0};
      else if (tmo) rsp_q <= {tag, {WIDTH{1'b0}}, 1'b1};
    end
  end
endmodule

// File: tb/tb_mod_reduction_scheduler.sv
// Bench for mod_reduction_scheduler: queued requesters, a behavioural reduction unit and a
// transaction-level round-robin model; with MODRED_TIMEOUT_EN it also exercises the watchdog.
module tb_mod_reduction_scheduler;
  localparam int WIDTH = 32, NUM_REQ = 4, ID_W = 2, P = 37, TMO = 8;

  logic                       clk = 1'b0, reset = 1'b1;
  logic [NUM_REQ-1:0]         req_valid = '0, req_ready;
  logic [NUM_REQ*2*WIDTH-1:0] req_a = '0;
  logic                       rsp_valid, rsp_err, red_reset, red_enable;
  logic                       red_done = 1'b0;
  logic [ID_W-1:0]            rsp_id;
  logic [WIDTH-1:0]           rsp_r, red_r = '0;
  logic [2*WIDTH-1:0]         red_a;

  mod_reduction_scheduler #(.P(P), .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W),
                            .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_err(rsp_err),
    .red_reset(red_reset), .red_enable(red_enable), .red_a(red_a),
    .red_done(red_done), .red_r(red_r));

  always #5 clk = ~clk;

  typedef struct { int id; logic [WIDTH-1:0] r; bit err; } exp_t;

  int checks = 0, errors = 0;
  logic [2*WIDTH-1:0] opq[NUM_REQ][$];
  int rd[NUM_REQ] = '{default: 0};
  logic [NUM_REQ-1:0] xfer = '0;
  exp_t expq[$];
  int ids_seen[$];
  int phase = 0, rr = 0, wcnt = 0, n_rsp = 0;
  logic [2*WIDTH-1:0] exp_a;
  logic [ID_W-1:0] last_id;
  logic [WIDTH-1:0] last_r;
  logic last_err;
  bit hang = 0, stray = 0;

  function automatic logic [WIDTH-1:0] ref_mod(input logic [2*WIDTH-1:0] a);
    longint s, m;
    s = signed'(a);
    m = s % P;
    if (m < 0) m += P;
    return m[WIDTH-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reduction unit: random latency, floored remainder mod P.
  logic [2*WIDTH-1:0] fop;
  int fcnt;
  bit fbusy = 0;
  always @(posedge clk) begin
    red_done <= 1'b0;
    if (red_reset) fbusy <= 1'b0;
    else if (red_enable) begin
      fbusy <= 1'b1; fcnt <= $urandom_range(0, 3); fop <= red_a;
    end else if (fbusy && !hang) begin
      if (fcnt == 0) begin red_done <= 1'b1; red_r <= ref_mod(fop); fbusy <= 1'b0; end
      else fcnt <= fcnt - 1;
    end
    if (stray) begin red_done <= 1'b1; red_r <= '1; end
  end

  // Requester driver: each requester presents the head of its own queue.
  always begin
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset) rd[i] = opq[i].size();
      else if (xfer[i]) rd[i]++;
      req_valid[i] = (rd[i] < opq[i].size());
      if (req_valid[i]) req_a[i*2*WIDTH +: 2*WIDTH] = opq[i][rd[i]];
      else              req_a[i*2*WIDTH +: 2*WIDTH] = '0;
    end
  end

  // Transaction model: 0 arbitrate, 1 issue, 2 wait for result, 3 response.
  always begin
    logic [NUM_REQ-1:0] exp_g;
    logic exp_rr;
    exp_t e;
    int g;
    @(negedge clk); #1;
    if (reset) begin
      phase = 0; rr = 0; wcnt = 0; expq.delete(); xfer = '0;
    end else begin
      exp_g = '0; exp_rr = 1'b0; g = 0;
      if (phase == 0)
        for (int k = 0; k < NUM_REQ; k++)
          if (exp_g == '0 && req_valid[(rr+k)%NUM_REQ]) exp_g[(rr+k)%NUM_REQ] = 1'b1;
`ifdef MODRED_TIMEOUT_EN
      if (phase == 2 && !red_done && wcnt == TMO-1) exp_rr = 1'b1;
`endif
      chk("req_ready", req_ready, exp_g);
      chk("red_enable", red_enable, phase == 1);
      chk("rsp_valid", rsp_valid, phase == 3);
      chk("red_reset", red_reset, exp_rr);
      xfer = req_valid & req_ready;
      case (phase)
        0: if (exp_g != '0) begin
             for (int k = 0; k < NUM_REQ; k++) if (exp_g[k]) g = k;
             exp_a = opq[g][rd[g]];
             expq.push_back('{id: g, r: ref_mod(exp_a), err: 1'b0});
             rr = (g + 1) % NUM_REQ;
             phase = 1;
           end
        1: begin chk("red_a", red_a, exp_a); phase = 2; wcnt = 0; end
        2: if (red_done) phase = 3;
           else if (exp_rr) begin
             e = expq[0]; e.r = '0; e.err = 1'b1; expq[0] = e; phase = 3;
           end else wcnt++;
        default: begin
          if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_r", rsp_r, e.r);
            chk("rsp_err", rsp_err, e.err);
          end
          ids_seen.push_back(int'(rsp_id));
          last_id = rsp_id; last_r = rsp_r; last_err = rsp_err;
          n_rsp++;
          phase = 0;
        end
      endcase
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_r"}, rsp_r, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_red_enable"}, red_enable, 0);
    chk({tag, "_red_a"}, red_a, 0);
    chk({tag, "_red_reset"}, red_reset, 1);
  endtask

  task automatic wait_rsp(input int target, input string tag);
    int n = 0;
    while (n_rsp < target && n < 2000) begin @(negedge clk); n++; end
    chk(tag, n_rsp >= target, 1);
    @(negedge clk);
  endtask

  initial begin
    int s, n, n0;
    logic [2*WIDTH-1:0] v;
    repeat (3) @(negedge clk);
    chk_reset_vals("init");
    reset = 1'b0;

    // Single op: 100 mod 37 = 26 from requester 0
    opq[0].push_back(64'd100);
    wait_rsp(1, "single_done");
    chk("single_id", last_id, 0); chk("single_r", last_r, 26); chk("single_err", last_err, 0);

    // Negative operand from requester 2: -5 mod 37 = 32
    v = -64'sd5;
    opq[2].push_back(v);
    wait_rsp(2, "neg_done");
    chk("neg_id", last_id, 2); chk("neg_r", last_r, 32);

    // Pointer now at 3; requesters 3 and 0 valid together
    s = ids_seen.size();
    opq[0].push_back(64'd7); opq[3].push_back(64'd11);
    wait_rsp(4, "wrap_done");
    chk("wrap_first", ids_seen[s], 3); chk("wrap_second", ids_seen[s+1], 0);

    // Reset while the reduction is outstanding
    opq[1].push_back(64'd500);
    n = 0;
    while (phase != 2 && n < 100) begin @(negedge clk); n++; end
    chk("reach_wait", n < 100, 1);
    n0 = n_rsp;
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid");
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("no_rsp_after_reset", n_rsp, n0);

    // Contention from a reset pointer: two ops queued on every requester
    s = ids_seen.size();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++) opq[i].push_back({$urandom, $urandom});
    wait_rsp(n0 + 8, "contention_done");
    for (int k = 0; k < 8; k++) chk("contention_order", ids_seen[s+k], k % NUM_REQ);

    // Stray done while idle must be ignored
    n0 = n_rsp;
    stray = 1'b1; @(negedge clk); stray = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_ignored", n_rsp, n0);

    // Randomized traffic
    n0 = n_rsp;
    for (int t = 0; t < 40; t++) begin
      opq[$urandom_range(0, NUM_REQ-1)].push_back({$urandom, $urandom});
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_rsp(n0 + 40, "random_done");

`ifdef MODRED_TIMEOUT_EN
    // Reduction unit never answers: watchdog aborts with an error response
    hang = 1'b1;
    n0 = n_rsp;
    opq[1].push_back(64'd123);
    wait_rsp(n0 + 1, "tmo_done");
    chk("tmo_id", last_id, 1); chk("tmo_r", last_r, 0); chk("tmo_err", last_err, 1);
    hang = 1'b0;
    opq[0].push_back(64'd74);
    wait_rsp(n0 + 2, "post_tmo_done");
    chk("post_tmo_r", last_r, 0); chk("post_tmo_err", last_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
